// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the decimation stages.
package fir_pkg;

  localparam int M            = 20;
  localparam int IN_WIDTH     = 35;
  localparam int CAPTURE_ADDR = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ROUND,
    S_PUSH
  } sum_state_e;

  // Width needed to add n signed values of width in_w without wrapping.
  function automatic int acc_width(input int in_w, input int n);
    return in_w + $clog2(n);
  endfunction

  // Round half up by 2^shift, then saturate to a signed out_w result.
  // Operates at 64 bits so any stage with acc width below ~60 can share it.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int                 shift,
                                                   input int                 out_w);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r     = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (r > max_v)      return max_v;
    else if (r < min_v) return min_v;
    else                return r;
  endfunction

endpackage

// File: rtl/fir_bank_sum_if.sv
// Sample stream from the bank summer toward the FFT/packetiser stage.
interface fir_bank_sum_if #(
  parameter int OUTPUT_WIDTH = 25
);
  logic signed [OUTPUT_WIDTH-1:0] dout;
  logic                           dout_valid;
  logic                           dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module fir_out_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    if (do_push) wr_d = wr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; dout_o is forced to 0 while empty,
  // so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/fir_bank_sum.sv
// Snapshots all bank outputs once per frame, sums them sequentially, rounds and
// saturates, and queues the decimated sample in a show-ahead output FIFO.
module fir_bank_sum #(
  parameter int M            = fir_pkg::M,
  parameter int NUM_BANKS    = 8,
  parameter int IN_WIDTH     = fir_pkg::IN_WIDTH,
  parameter int OUTPUT_WIDTH = 25,
  parameter int SHIFT        = 13,
  parameter int CAPTURE_ADDR = fir_pkg::CAPTURE_ADDR,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(M)-1:0]          tap_addr_i,
  input  logic [NUM_BANKS*IN_WIDTH-1:0] bank_dout_i,
  fir_bank_sum_if.master                out_if,
  output logic                          overflow_o,
  output logic                          capture_miss_o
);
  import fir_pkg::*;

  localparam int TAP_W = $clog2(M);
  localparam int ACC_W = acc_width(IN_WIDTH, NUM_BANKS);
  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  sum_state_e                     state_q, state_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic signed [IN_WIDTH-1:0]     snap_q [NUM_BANKS];
  logic signed [OUTPUT_WIDTH-1:0] result_q, result_d;
  logic                           overflow_q, overflow_d;
  logic                           miss_q, miss_d;
  logic                           snap_en, capture_hit, fifo_push, fifo_full, fifo_empty;

  assign capture_hit = (tap_addr_i == TAP_W'(CAPTURE_ADDR));

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    miss_d     = miss_q;
    snap_en    = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture_hit) begin
          snap_en = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + ACC_W'(snap_q[idx_q]);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_BANKS - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = OUTPUT_WIDTH'(round_sat(64'(acc_q), SHIFT, OUTPUT_WIDTH));
        state_d  = S_PUSH;
      end
      S_PUSH: begin
        fifo_push = 1'b1;
        // A full FIFO only takes the sample if the head leaves on this edge.
        if (fifo_full && !out_if.dout_ready) overflow_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture_hit && state_q != S_IDLE) miss_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      miss_q     <= miss_d;
    end
  end

  // NOTE: the snapshot array is small and reset explicitly so a partial frame
  // can never leak old bank values after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) snap_q[i] <= '0;
    end else if (snap_en) begin
      for (int i = 0; i < NUM_BANKS; i++) snap_q[i] <= bank_dout_i[i*IN_WIDTH +: IN_WIDTH];
    end
  end

  fir_out_fifo #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (result_q),
    .pop_i   (out_if.dout_ready),
    .dout_o  (out_if.dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign out_if.dout_valid = !fifo_empty;
  assign overflow_o        = overflow_q;
  assign capture_miss_o    = miss_q;

endmodule
